// File: rtl/pluck_exciter.sv
// Karplus-Strong pluck exciter: one LFSR noise burst of 2*max(len>>octave,4) samples per note-on.
// Optional amplitude scaling by latched velocity when PLUCK_EXCITER_VELOCITY_EN is defined.
module pluck_exciter #(
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2345,
  parameter int unsigned HOLDOFF   = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               note_on,
  input  logic [6:0]         velocity,
  input  logic [9:0]         shift_register_length,
  input  logic [1:0]         octave,
  output logic signed [31:0] dnoise,
  output logic               trig,
  output logic               ready
);

  localparam int unsigned CNT_W  = 11;
  localparam int unsigned HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  // Galois taps for x^32+x^22+x^2+x+1 (right-shifting form)
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic              note_prev_q, note_prev_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  load_q, load_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              trig_q, trig_d;
  logic              ready_q, ready_d;
  logic [31:0]       dnoise_q, dnoise_d;
  logic [9:0]        len_c;
  logic [9:0]        len_clamped_c;
  logic [31:0]       sample_c;

`ifdef PLUCK_EXCITER_VELOCITY_EN
  logic [6:0] vel_q, vel_d;

  // Velocity is taken live on the accepting IDLE cycle, then held for the burst
  always_comb begin
    vel_d    = (state_q == S_IDLE) ? velocity : vel_q;
    sample_c = 32'(($signed(40'($signed(lfsr_q))) * $signed(40'($signed({1'b0, vel_d})))) >>> 7);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vel_q <= 7'd0;
    else          vel_q <= vel_d;
  end
`else
  logic unused_velocity;
  assign unused_velocity = ^velocity;

  always_comb begin
    sample_c = lfsr_q;
  end
`endif

  always_comb begin
    len_c         = shift_register_length >> octave;
    len_clamped_c = (len_c < 10'd4) ? 10'd4 : len_c;
  end

  always_comb begin
    lfsr_d      = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);
    note_prev_d = note_on;
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_d      = load_q;
    hold_d      = hold_q;
    trig_d      = 1'b0;
    dnoise_d    = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (note_on && !note_prev_q) begin
          load_d   = {len_clamped_c, 1'b0};
          cnt_d    = '0;
          state_d  = S_BURST;
          trig_d   = 1'b1;
          dnoise_d = sample_c;
        end
      end
      S_BURST: begin
        cnt_d    = cnt_q + CNT_W'(1);
        trig_d   = 1'b1;
        dnoise_d = sample_c;
        if (cnt_q == CNT_W'(load_q - CNT_W'(1))) begin
          state_d  = S_HOLD;
          cnt_d    = '0;
          hold_d   = '0;
          trig_d   = 1'b0;
          dnoise_d = 32'd0;
        end
      end
      S_HOLD: begin
        hold_d = hold_q + HOLD_W'(1);
        if (hold_q == HOLD_W'(HOLDOFF - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      note_prev_q <= 1'b1;
      cnt_q       <= '0;
      load_q      <= '0;
      hold_q      <= '0;
      trig_q      <= 1'b0;
      ready_q     <= 1'b1;
      dnoise_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      note_prev_q <= note_prev_d;
      cnt_q       <= cnt_d;
      load_q      <= load_d;
      hold_q      <= hold_d;
      trig_q      <= trig_d;
      ready_q     <= ready_d;
      dnoise_q    <= dnoise_d;
    end
  end

  assign dnoise = $signed(dnoise_q);
  assign trig   = trig_q;
  assign ready  = ready_q;

endmodule

// File: tb/tb_pluck_exciter.sv
// Scoreboard bench for pluck_exciter: stimulus queues expected bursts, a monitor checks length,
// holdoff and every sample against a reference LFSR. Honors PLUCK_EXCITER_VELOCITY_EN.
module tb_pluck_exciter;

  localparam logic [31:0] SEED = 32'hACE1_2345;
  localparam int HOLDOFF = 64;

  logic               clk = 1'b0;
  logic               reset_n = 1'b1;
  logic               note_on = 1'b0;
  logic [6:0]         velocity = 7'd0;
  logic [9:0]         shift_register_length = 10'd0;
  logic [1:0]         octave = 2'd0;
  logic signed [31:0] dnoise;
  logic               trig;
  logic               ready;

  typedef struct {
    int load;
    int vel;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   mst = 0;

  logic [31:0] lfsr_m;
  logic [31:0] lfsr_prev_m;

  pluck_exciter #(.LFSR_SEED(SEED), .HOLDOFF(HOLDOFF)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .note_on              (note_on),
    .velocity             (velocity),
    .shift_register_length(shift_register_length),
    .octave               (octave),
    .dnoise               (dnoise),
    .trig                 (trig),
    .ready                (ready)
  );

  always #5 clk = ~clk;

  // Reference noise source: x^32+x^22+x^2+x+1, shifting toward bit 0
  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    logic [31:0] n;
    n = l >> 1;
    if (l[0]) n = n ^ ((32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1);
    return n;
  endfunction

  function automatic logic [31:0] exp_sample(input logic [31:0] l, input int v);
`ifdef PLUCK_EXCITER_VELOCITY_EN
    longint p;
    p = longint'($signed(l)) * longint'(v);
    p = p >>> 7;
    return p[31:0];
`else
    return (v < 0) ? 32'd0 : l;
`endif
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_m      <= SEED;
      lfsr_prev_m <= SEED;
    end else begin
      lfsr_prev_m <= lfsr_m;
      lfsr_m      <= lfsr_next(lfsr_m);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: follows each burst from trig rise through holdoff
  initial begin
    exp_t cur;
    int   cnt;
    int   hcnt;
    cur = '{load: 0, vel: 0};
    cnt = 0;
    hcnt = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mst = 0;
        continue;
      end
      case (mst)
        0: begin
          if (trig) begin
            if (sb_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_burst actual=trig expected=idle t=%0t", $time);
              cur = '{load: 0, vel: 0};
            end else begin
              cur = sb_q.pop_front();
            end
            chk("burst_ready", 32'(ready), 32'd0);
            chk("sample", dnoise, exp_sample(lfsr_prev_m, cur.vel));
            cnt = 1;
            mst = 1;
          end else begin
            chk("idle_ready", 32'(ready), 32'd1);
            chk("idle_dnoise", dnoise, 32'd0);
          end
        end
        1: begin
          if (trig) begin
            cnt++;
            chk("sample", dnoise, exp_sample(lfsr_prev_m, cur.vel));
            chk("burst_ready", 32'(ready), 32'd0);
          end else begin
            chk("burst_len", 32'(cnt), 32'(cur.load));
            chk("fall_dnoise", dnoise, 32'd0);
            chk("hold_ready", 32'(ready), 32'd0);
            hcnt = 1;
            mst = 2;
          end
        end
        default: begin
          if (ready) begin
            chk("holdoff", 32'(hcnt), 32'(HOLDOFF));
            mst = 0;
          end else begin
            chk("hold_quiet", {31'd0, trig} | dnoise, 32'd0);
            hcnt++;
            if (hcnt > HOLDOFF + 8) begin
              chk("hold_timeout", 32'(hcnt), 32'(HOLDOFF));
              mst = 0;
            end
          end
        end
      endcase
    end
  end

  // One-cycle note-on pulse; exp_load 0 means the pulse must be ignored
  task automatic pulse(input int len, input int oct, input int vel, input int exp_load);
    @(posedge clk);
    #1;
    shift_register_length = 10'(len);
    octave = 2'(oct);
    velocity = 7'(vel);
    if (exp_load > 0) sb_q.push_back('{load: exp_load, vel: vel});
    note_on = 1'b1;
    @(posedge clk);
    #1;
    note_on = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      #1;
      if (ready && mst == 0 && !trig) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 32'(ready), 32'd1);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_dnoise", dnoise, 32'd0);
    chk("rst_trig", 32'(trig), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_trig", 32'(trig), 32'd0);
    chk("post_rst_ready", 32'(ready), 32'd1);

    // Key held through reset must not trigger
    @(posedge clk);
    #1 reset_n = 1'b0;
    note_on = 1'b1;
    shift_register_length = 10'd400;
    octave = 2'd1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("held_key_trig", 32'(trig), 32'd0);
    chk("held_key_ready", 32'(ready), 32'd1);
    note_on = 1'b0;
    pulse(400, 1, 127, 400);
    wait_idle();

    // Clamp: 10>>2 = 2 -> 4 -> 8 samples
    pulse(10, 2, 64, 8);
    wait_idle();

    // Overlap: retrigger mid-burst with new controls, and again during holdoff
    pulse(400, 1, 127, 400);
    repeat (100) @(posedge clk);
    pulse(100, 0, 5, 0);
    for (int i = 0; i < 1000 && trig; i++) @(negedge clk);
    repeat (10) @(posedge clk);
    pulse(200, 0, 9, 0);
    wait_idle();
    pulse(20, 0, 127, 40);
    wait_idle();

    // Velocity 0: silent burst when scaling is built in
    pulse(400, 1, 0, 400);
    wait_idle();

    // Reset mid-burst, outputs must clear without a clock edge
    pulse(400, 1, 127, 400);
    repeat (48) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_trig", 32'(trig), 32'd0);
    chk("async_dnoise", dnoise, 32'd0);
    chk("async_ready", 32'(ready), 32'd1);
    void'(sb_q.size());
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    pulse(400, 1, 127, 400);
    wait_idle();

    repeat (5) @(posedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pluck_exciter.md
# pluck_exciter

Excitation source for the Karplus-Strong string voice. On each note-on it emits one burst of pseudo-random samples on `dnoise` and holds `trig` high for the burst, so the string shift register loads a fresh noise period. It sits in front of `config_shift_register`, drives its `dnoise` and `trig` inputs, and uses the same `shift_register_length`/`octave` controls to size the burst.

## Interface
- `LFSR_SEED`, default 32'hACE1_2345: LFSR reset value; must be nonzero.
- `HOLDOFF`, default 64: minimum idle cycles after a burst before the next note-on is accepted; must be ≥ 1.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `note_on`  in  1  key level, synchronous to `clk`; its rising edge requests a burst.
- `velocity`  in  7  unsigned burst amplitude, 0..127.
- `shift_register_length`  in  10  nominal string length in samples.
- `octave`  in  2  right-shift applied to the length.
- `dnoise`  out  32 signed  excitation sample; 0 outside a burst.
- `trig`  out  1  high for every cycle of a burst.
- `ready`  out  1  high only in IDLE, when a note-on would be accepted.

## Operation
- The LFSR is a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1.
  - It advances every cycle, free-running in all states.
  - Reset loads it with `LFSR_SEED`.
- Edge detect: `note_prev` is registered from `note_on` and resets to 1, so a key held through reset never triggers.
- A note-on is a cycle where `note_on`=1 and `note_prev`=0.
- FSM states: IDLE, BURST, HOLD.
  - IDLE: `ready`=1, `trig`=0, `dnoise`=0.
    - On note-on, compute len = `shift_register_length`>>`octave` and clamp it to a minimum of 4.
    - Latch load = len<<1 (range 8..2046) and latch `velocity`.
    - Clear the 11-bit burst counter and go to BURST.
  - BURST: `trig`=1 and `dnoise` = scaled LFSR value. The counter increments every cycle. When counter = load-1, go to HOLD with the counter cleared.
  - HOLD: `trig`=0, `dnoise`=0, `ready`=0. After `HOLDOFF` cycles, go to IDLE.
- Note-on edges in BURST or HOLD are dropped, not queued.
- Changes to `shift_register_length`, `octave` or `velocity` during BURST or HOLD do not affect the current burst.
- Asserting reset mid-burst does the following, asynchronously:
  - state goes to IDLE;
  - `trig`, `dnoise` and the counter go to 0;
  - `ready` goes to 1.

## Timing
- Reset values: `dnoise`=0, `trig`=0, `ready`=1, state IDLE, LFSR=`LFSR_SEED`, `note_prev`=1.
- All outputs are registered.
- A note-on sampled at edge N produces, after edge N:
  - `trig`=1;
  - the first burst sample;
  - `ready`=0.
- `trig` stays high for exactly load cycles. It falls after edge N+load.
- `ready` returns to 1 after edge N+load+`HOLDOFF`. The earliest next accepted note-on is at that edge.
- Each burst cycle presents one new LFSR value, so there are no repeated samples within a burst.
- Consumer constraint: `trig` must be at least one debounce window long. The minimum burst of 8 cycles meets `input_debounce` only when its window is ≤ 8 cycles. Longer windows require an external stretcher; this block does not stretch `trig`.

## Configuration
- Macro: `PLUCK_EXCITER_VELOCITY_EN`.
- Defined:
  - `dnoise` = (signed LFSR × {1'b0, latched velocity}) >>> 7.
  - The product is 39 bits signed, arithmetically shifted and truncated to 32 bits.
  - Velocity 0 gives an all-zero burst; velocity 127 gives 127/128 of full scale.
- Undefined:
  - `dnoise` = LFSR value reinterpreted as signed 32-bit.
  - `velocity` is ignored and not latched; no multiplier is instantiated.

## Test plan
- Reset: hold `reset_n` low for 5 cycles, then release with `note_on`=0 → `dnoise`=0, `trig`=0, `ready`=1.
  - Then hold `note_on` high through another reset release → no burst until `note_on` falls and rises again.
- Sizing: `shift_register_length`=400, `octave`=1, one-cycle `note_on` pulse → `trig` high for exactly 400 cycles; `ready` low for 400+64 cycles.
- Clamp: `shift_register_length`=10, `octave`=2 (10>>2=2, clamped to 4) → `trig` high for exactly 8 cycles.
- Overlap: `shift_register_length`=400, `octave`=1 (400-cycle burst); a second note-on 100 cycles into the burst and a third during HOLD → both ignored. The burst is still 400 cycles, and the next burst starts only on an edge after `ready` returns to 1.
- Amplitude, macro defined: `velocity`=0 → all 400 burst samples are 0. `velocity`=127 → each sample equals (LFSR×127)>>>7 from a reference model seeded with `LFSR_SEED`.
  - Macro undefined: samples match the raw LFSR sequence bit-exactly.
- Reset mid-burst: drop `reset_n` 50 cycles into a 400-cycle burst → `trig` and `dnoise` go to 0 without waiting for a clock edge, and `ready`=1.
  - After release, a fresh note-on gives a full 400-cycle burst restarting from `LFSR_SEED`.
